// File: rtl/mem_port_arbiter.sv
// Purpose : shares one unified memory port between instruction fetch (IF) and load/store (LS).
// Latency : grant in cycle N, memory access N+1..N+MEM_LAT, rvalid pulse in N+MEM_LAT+1.
// Backpr. : requesters hold req until gnt; grants only issued while IDLE (busy=0).
//
// Ports:
//   clk_i, rst                   clock, asynchronous active-low reset
//   if_req/if_addr -> if_gnt     fetch request/accept; if_rvalid/if_rdata fetch response
//   ls_req/ls_we/ls_mode/ls_addr/ls_wdata -> ls_gnt   load/store request/accept
//   ls_rvalid/ls_rdata           load/store completion (rdata 0 for stores)
//   busy                         arbiter not idle
//   mem_re/mem_we/mem_mode/mem_addr/mem_wdata/mem_rdata   unified memory port
module mem_port_arbiter #(
    parameter int MEM_LAT    = 2,
    parameter int MAX_STREAK = 3,
    parameter int STREAK_W   = 2
) (
    input  logic        clk_i,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [2:0]  ls_mode,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_gnt,
    output logic        ls_rvalid,
    output logic [31:0] ls_rdata,
    output logic        busy,
    output logic        mem_re,
    output logic        mem_we,
    output logic [2:0]  mem_mode,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_owner_ls;
    logic                 r_we;
    logic [CNT_W-1:0]     r_cnt;
    logic [STREAK_W-1:0]  r_streak;
    logic [31:0]          r_addr;
    logic [31:0]          r_wdata;
    logic [2:0]           r_mode;
    logic [31:0]          r_if_rdata;
    logic [31:0]          r_ls_rdata;

    logic w_idle;
    logic w_streak_full;
    logic w_gnt_if;
    logic w_gnt_ls;
    logic w_last;

    // Grants are gated by rst so that every output reads 0 while reset is held.
    assign w_idle        = (r_state == S_IDLE);
    assign w_streak_full = (r_streak == STREAK_W'(MAX_STREAK));
    assign w_gnt_if      = rst & w_idle & if_req & (~ls_req | w_streak_full);
    assign w_gnt_ls      = rst & w_idle & ls_req & ~w_gnt_if;
    assign w_last        = (r_state == S_ACCESS) && (r_cnt == '0);

    // State register
    always_ff @(posedge clk_i or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_gnt_if || w_gnt_ls) w_state_nxt = S_ACCESS;
            S_ACCESS: if (w_last) w_state_nxt = S_RESP;
            S_RESP:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Access registers, latency counter, starvation streak and response data
    always_ff @(posedge clk_i or negedge rst) begin
        if (!rst) begin
            r_owner_ls <= 1'b0;
            r_we       <= 1'b0;
            r_cnt      <= '0;
            r_streak   <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_mode     <= '0;
            r_if_rdata <= '0;
            r_ls_rdata <= '0;
        end else if (w_gnt_if || w_gnt_ls) begin
            r_owner_ls <= w_gnt_ls;
            r_addr     <= w_gnt_ls ? ls_addr  : if_addr;
            r_mode     <= w_gnt_ls ? ls_mode  : 3'b010;
            r_wdata    <= w_gnt_ls ? ls_wdata : 32'd0;
            r_we       <= w_gnt_ls & ls_we;
            r_cnt      <= CNT_W'(MEM_LAT - 1);
            // Streak only grows while IF is actually waiting behind LS.
            if (w_gnt_if || !if_req) begin
                r_streak <= '0;
            end else if (!w_streak_full) begin
                r_streak <= r_streak + STREAK_W'(1);
            end
        end else if (r_state == S_ACCESS) begin
            if (w_last) begin
                if (r_owner_ls) begin
                    r_ls_rdata <= r_we ? 32'd0 : mem_rdata;
                end else begin
                    r_if_rdata <= mem_rdata;
                end
            end else begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    // Output logic
    always_comb begin
        if_gnt    = w_gnt_if;
        ls_gnt    = w_gnt_ls;
        busy      = ~w_idle;
        mem_re    = (r_state == S_ACCESS) & ~r_we;
        mem_we    = (r_state == S_ACCESS) &  r_we;
        mem_mode  = r_mode;
        mem_addr  = r_addr;
        mem_wdata = r_wdata;
        if_rvalid = (r_state == S_RESP) & ~r_owner_ls;
        ls_rvalid = (r_state == S_RESP) &  r_owner_ls;
        if_rdata  = r_if_rdata;
        ls_rdata  = r_ls_rdata;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose : randomized + directed bench for mem_port_arbiter with a transaction-level model.
// Latency : expected responses are queued at grant and popped when the DUT pulses rvalid.
// Backpr. : requesters hold req until they observe gnt (or occasionally abandon it).
module tb_mem_port_arbiter;

    localparam int MEM_LAT    = 2;
    localparam int MAX_STREAK = 3;
    localparam int STREAK_W   = 2;

    logic        clk_i = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_req;
    logic        ls_we;
    logic [2:0]  ls_mode;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_gnt;
    logic        ls_rvalid;
    logic [31:0] ls_rdata;
    logic        busy;
    logic        mem_re;
    logic        mem_we;
    logic [2:0]  mem_mode;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    mem_port_arbiter #(
        .MEM_LAT   (MEM_LAT),
        .MAX_STREAK(MAX_STREAK),
        .STREAK_W  (STREAK_W)
    ) dut (
        .clk_i    (clk_i),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_gnt   (if_gnt),
        .if_rvalid(if_rvalid),
        .if_rdata (if_rdata),
        .ls_req   (ls_req),
        .ls_we    (ls_we),
        .ls_mode  (ls_mode),
        .ls_addr  (ls_addr),
        .ls_wdata (ls_wdata),
        .ls_gnt   (ls_gnt),
        .ls_rvalid(ls_rvalid),
        .ls_rdata (ls_rdata),
        .busy     (busy),
        .mem_re   (mem_re),
        .mem_we   (mem_we),
        .mem_mode (mem_mode),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          ls;
        bit          we;
        logic [31:0] addr;
        logic [2:0]  mode;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          g;
    } txn_t;

    txn_t        q[$];
    txn_t        cur;
    bit          have_cur = 1'b0;
    int          next_free = 0;
    int          streak = 0;
    logic [31:0] last_if = '0;
    logic [31:0] last_ls = '0;

    bit          rand_en = 1'b0;
    int          dir_if_cnt = 0;
    int          dir_ls_cnt = 0;
    logic [31:0] dir_if_addr = '0;
    logic [31:0] dir_ls_addr = '0;
    logic [31:0] dir_ls_wdata = '0;
    logic [2:0]  dir_ls_mode = '0;
    bit          dir_ls_we = 1'b0;

    // Memory contents as a pure function of the address.
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // IF requester
    initial begin : drv_if
        bit t;
        bit dropped;
        int done;
        done = 0;
        if_req = 1'b0;
        if_addr = '0;
        forever begin
            @(negedge clk_i);
            t = if_gnt;
            @(posedge clk_i);
            #1;
            dropped = 1'b0;
            if (t) begin
                if_req = 1'b0;
            end else if (if_req && rand_en && $urandom_range(0, 15) == 0) begin
                if_req = 1'b0;
                dropped = 1'b1;
            end
            if (!if_req && !dropped) begin
                if (done < dir_if_cnt) begin
                    if_req = 1'b1;
                    if_addr = dir_if_addr;
                    done++;
                end else if (rand_en && $urandom_range(0, 3) != 0) begin
                    if_req = 1'b1;
                    if_addr = $urandom;
                end
            end
        end
    end

    // LS requester
    initial begin : drv_ls
        bit t;
        bit dropped;
        int done;
        done = 0;
        ls_req = 1'b0;
        ls_we = 1'b0;
        ls_mode = '0;
        ls_addr = '0;
        ls_wdata = '0;
        forever begin
            @(negedge clk_i);
            t = ls_gnt;
            @(posedge clk_i);
            #1;
            dropped = 1'b0;
            if (t) begin
                ls_req = 1'b0;
            end else if (ls_req && rand_en && $urandom_range(0, 15) == 0) begin
                ls_req = 1'b0;
                dropped = 1'b1;
            end
            if (!ls_req && !dropped) begin
                if (done < dir_ls_cnt) begin
                    ls_req = 1'b1;
                    ls_we = dir_ls_we;
                    ls_addr = dir_ls_addr;
                    ls_wdata = dir_ls_wdata;
                    ls_mode = dir_ls_mode;
                    done++;
                end else if (rand_en && $urandom_range(0, 3) != 0) begin
                    ls_req = 1'b1;
                    ls_we = $urandom_range(0, 1) == 1;
                    ls_addr = $urandom;
                    ls_wdata = $urandom;
                    ls_mode = 3'($urandom_range(0, 7));
                end
            end
        end
    end

    // Reference model: grant decisions, port activity, memory data; pushes expected responses.
    always @(negedge clk_i) begin : model
        bit   idle;
        bit   e_if;
        bit   e_ls;
        bit   in_acc;
        txn_t t;
        if (!rst) begin
            chk("reset_ctrl", {if_gnt, ls_gnt, if_rvalid, ls_rvalid, busy, mem_re, mem_we, mem_mode}, 64'd0);
            chk("reset_addr", mem_addr, 64'd0);
            chk("reset_wdata", mem_wdata, 64'd0);
            chk("reset_rdata", {if_rdata, ls_rdata}, 64'd0);
            next_free = 0;
            streak    = 0;
            have_cur  = 1'b0;
            q.delete();
            last_if   = '0;
            last_ls   = '0;
            mem_rdata = $urandom;
        end else begin
            idle = (cyc >= next_free);
            e_if = idle && if_req && (!ls_req || streak == MAX_STREAK);
            e_ls = idle && ls_req && !e_if;
            chk("grant", {if_gnt, ls_gnt}, {e_if, e_ls});
            chk("busy", busy, !idle);
            in_acc = have_cur && (cyc > cur.g) && (cyc <= cur.g + MEM_LAT);
            chk("mem_en", {mem_re, mem_we}, {in_acc && !cur.we, in_acc && cur.we});
            if (in_acc) begin
                chk("mem_addr", mem_addr, cur.addr);
                chk("mem_wdata", mem_wdata, cur.wdata);
                chk("mem_mode", mem_mode, cur.mode);
            end
            // Only the final access cycle carries real data; anything else is noise.
            if (in_acc && cyc == cur.g + MEM_LAT && !cur.we) mem_rdata = mem_fn(cur.addr);
            else mem_rdata = $urandom;
            if (e_if || e_ls) begin
                t.ls    = e_ls;
                t.we    = e_ls && ls_we;
                t.addr  = e_ls ? ls_addr : if_addr;
                t.mode  = e_ls ? ls_mode : 3'b010;
                t.wdata = e_ls ? ls_wdata : 32'd0;
                t.rdata = t.we ? 32'd0 : mem_fn(t.addr);
                t.g     = cyc;
                q.push_back(t);
                cur       = t;
                have_cur  = 1'b1;
                next_free = cyc + MEM_LAT + 2;
                if (e_if || !if_req) streak = 0;
                else if (streak < MAX_STREAK) streak = streak + 1;
            end
        end
    end

    // Response monitor: pops the scoreboard whenever the DUT signals completion.
    always @(negedge clk_i) begin : monitor
        txn_t t;
        if (rst) begin
            while (q.size() > 0 && q[0].g + MEM_LAT + 1 < cyc) begin
                t = q.pop_front();
                chk("missed_rvalid", 64'd0, 64'd1);
            end
            if (if_rvalid || ls_rvalid) begin
                if (q.size() == 0) begin
                    chk("unexpected_rvalid", {if_rvalid, ls_rvalid}, 64'd0);
                end else begin
                    t = q.pop_front();
                    chk("rvalid_owner", {if_rvalid, ls_rvalid}, {!t.ls, t.ls});
                    chk("rvalid_cycle", cyc, t.g + MEM_LAT + 1);
                    if (t.ls) last_ls = t.rdata;
                    else      last_if = t.rdata;
                end
            end
            chk("if_rdata", if_rdata, last_if);
            chk("ls_rdata", ls_rdata, last_ls);
        end
    end

    initial begin : main
        int n;
        rst = 1'b0;
        repeat (3) @(posedge clk_i);
        #2 rst = 1'b1;

        rand_en = 1'b1;
        repeat (3000) @(posedge clk_i);
        rand_en = 1'b0;

        n = 0;
        while (!(!if_req && !ls_req && q.size() == 0 && !busy) && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        chk("drain", {if_req, ls_req, busy}, 64'd0);

        // Reset asserted in the middle of a fetch access.
        @(negedge clk_i);
        dir_if_addr = 32'h0000_0400;
        dir_if_cnt++;
        n = 0;
        while (!mem_re && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        chk("fetch_started", mem_re, 64'd1);
        #2 rst = 1'b0;
        #1 chk("async_reset_outputs",
               {if_gnt, ls_gnt, if_rvalid, ls_rvalid, busy, mem_re, mem_we, mem_mode}, 64'd0);
        repeat (2) @(negedge clk_i);
        @(posedge clk_i);
        #2 rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            chk("no_rvalid_after_reset", {if_rvalid, ls_rvalid}, 64'd0);
        end

        // Simultaneous load and fetch: load first, fetch right after.
        @(negedge clk_i);
        dir_ls_we    = 1'b0;
        dir_ls_addr  = 32'h0000_0100;
        dir_ls_wdata = 32'h0;
        dir_ls_mode  = 3'b010;
        dir_if_addr  = 32'h0000_0200;
        dir_ls_cnt++;
        dir_if_cnt++;
        repeat (12) @(negedge clk_i);

        // Store: memory write with the requested address/data/mode, ls_rdata becomes 0.
        dir_ls_we    = 1'b1;
        dir_ls_addr  = 32'h0000_0040;
        dir_ls_wdata = 32'h1234_5678;
        dir_ls_mode  = 3'b010;
        dir_ls_cnt++;
        repeat (10) @(negedge clk_i);
        chk("ls_rdata_after_store", ls_rdata, 64'd0);

        chk("scoreboard_empty", q.size(), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
